uart_rx: RTL

Serial receiver for the team's 10-bit UART frame: one start bit (0), 7 data bits LSB first, one even-parity bit (XOR of the 7 data bits), one stop bit (1). It oversamples the asynchronous `rx` line, samples each bit at its centre, and presents the recovered 7-bit word with a one-cycle valid strobe and parity/framing error flags. It sits at the receive end of the link driven by the UART transmitter and feeds the protocol layer above.

---
 rtl/uart_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 7 data bits LSB first, even parity, 1 stop.
// Oversamples rx at CLKS_PER_BIT clocks per bit and samples each bit at its centre.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [6:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic          rx_s_d;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    idx;
    logic [6:0]    shift;
    logic          par_err_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            idx        <= '0;
            shift      <= '0;
            par_err_r  <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, never a held-low line.
                    if (rx_s_d && !rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt     <= '0;
                        shift[idx]  <= rx_s;
                        if (idx == 3'd6) begin
                            state <= PARITY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt   <= '0;
                        par_err_r <= rx_s ^ (^shift);
                        state     <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Outputs are loaded on entry so they and valid are visible during DONE.
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt    <= '0;
                        data       <= shift;
                        parity_err <= par_err_r;
                        frame_err  <= ~rx_s;
                        valid      <= 1'b1;
                        state      <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
